cc_wrport_arbiter: RTL and testbench

Register-file write-port arbiter for the micro datapath. It accepts write requests from up to `NUM_REQ` producers (ALU result, memory load, PC/trap save), grants one per cycle, and drives the registered 6-bit write selection and data that feed the register-file write decoder and register bank. Register 0 is hard-wired, and selections at or above `NUM_REGS` are dropped and flagged.

---
 rtl/cc_wrport_arbiter.sv | 129 ++++++++++++
 tb/tb_cc_wrport_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/cc_wrport_arbiter.sv
// Register-file write-port arbiter: grants one producer per cycle and registers its selection/data.
// Define CC_WRPORT_ARBITER_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module cc_wrport_arbiter #(
    parameter int DATAWIDTH_BUS       = 32,
    parameter int DATAWIDTH_SELECTION = 6,
    parameter int NUM_REGS            = 38,
    parameter int NUM_REQ             = 3
) (
    input  logic                                   CC_WRPORT_ARBITER_CLOCK_50,
    input  logic                                   CC_WRPORT_ARBITER_RESET_InLow,
    input  logic [NUM_REQ-1:0]                     CC_WRPORT_ARBITER_Req_In,
    input  logic [NUM_REQ*DATAWIDTH_SELECTION-1:0] CC_WRPORT_ARBITER_Addr_In,
    input  logic [NUM_REQ*DATAWIDTH_BUS-1:0]       CC_WRPORT_ARBITER_Data_In,
    output logic [NUM_REQ-1:0]                     CC_WRPORT_ARBITER_Grant_Out,
    output logic [DATAWIDTH_SELECTION-1:0]         CC_WRPORT_ARBITER_Selection_Out,
    output logic [DATAWIDTH_BUS-1:0]               CC_WRPORT_ARBITER_Data_Out,
    output logic                                   CC_WRPORT_ARBITER_WriteValid_Out,
    output logic                                   CC_WRPORT_ARBITER_Error_Out
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [DATAWIDTH_SELECTION:0] NUM_REGS_W = NUM_REGS[DATAWIDTH_SELECTION:0];
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0]             grant_q, grant_d;
    logic [DATAWIDTH_SELECTION-1:0] sel_q, sel_d;
    logic [DATAWIDTH_BUS-1:0]       data_q, data_d;
    logic                           wv_q, wv_d;
    logic                           err_q, err_d;
    logic [PTR_W-1:0]               ptr_q, ptr_d;

    logic [DATAWIDTH_SELECTION-1:0] addr_a_s [NUM_REQ];
    logic [DATAWIDTH_BUS-1:0]       data_a_s [NUM_REQ];
    logic [NUM_REQ-1:0]             eligible_s;
    logic                           found_s;
    logic [PTR_W-1:0]               win_idx_s;
    int                             idx_s;
    logic [DATAWIDTH_SELECTION-1:0] win_addr_s;
    logic [DATAWIDTH_BUS-1:0]       win_data_s;
    logic                           addr_zero_s;
    logic                           addr_oor_s;

    // Unpack the flat per-requester buses into arrays.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            addr_a_s[k] = CC_WRPORT_ARBITER_Addr_In[k*DATAWIDTH_SELECTION +: DATAWIDTH_SELECTION];
            data_a_s[k] = CC_WRPORT_ARBITER_Data_In[k*DATAWIDTH_BUS +: DATAWIDTH_BUS];
        end
    end

    // A requester holding the grant this cycle sits out, so a dropping request is never granted twice.
    assign eligible_s = CC_WRPORT_ARBITER_Req_In & ~grant_q;

    // Winner search: rotate from pointer+1 in round-robin mode, from index 0 otherwise.
    always_comb begin
        found_s   = 1'b0;
        win_idx_s = '0;
        idx_s     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef CC_WRPORT_ARBITER_RR_EN
            idx_s = (int'(ptr_q) + 1 + k) % NUM_REQ;
`else
            idx_s = k;
`endif
            if (!found_s && eligible_s[idx_s]) begin
                found_s   = 1'b1;
                win_idx_s = PTR_W'(idx_s);
            end else begin
                found_s   = found_s;
            end
        end
    end

    assign win_addr_s  = addr_a_s[win_idx_s];
    assign win_data_s  = data_a_s[win_idx_s];
    assign addr_zero_s = (win_addr_s == {DATAWIDTH_SELECTION{1'b0}});
    assign addr_oor_s  = ({1'b0, win_addr_s} >= NUM_REGS_W);

    // Next-state for grant, write port outputs, sticky error and last-winner pointer.
    always_comb begin
        grant_d = '0;
        sel_d   = '0;
        data_d  = '0;
        wv_d    = 1'b0;
        err_d   = err_q;
        ptr_d   = ptr_q;
        if (found_s) begin
            grant_d[win_idx_s] = 1'b1;
            data_d             = win_data_s;
            ptr_d              = win_idx_s;
            if (addr_zero_s || addr_oor_s) begin
                sel_d = '0;
                wv_d  = 1'b0;
                err_d = err_q | addr_oor_s;
            end else begin
                sel_d = win_addr_s;
                wv_d  = 1'b1;
            end
        end else begin
            grant_d = '0;
        end
    end

    // State registers; the pointer resets to the last index so requester 0 wins first.
    always_ff @(posedge CC_WRPORT_ARBITER_CLOCK_50 or negedge CC_WRPORT_ARBITER_RESET_InLow) begin
        if (!CC_WRPORT_ARBITER_RESET_InLow) begin
            grant_q <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            wv_q    <= 1'b0;
            err_q   <= 1'b0;
            ptr_q   <= PTR_RST;
        end else begin
            grant_q <= grant_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            wv_q    <= wv_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
        end
    end

    assign CC_WRPORT_ARBITER_Grant_Out      = grant_q;
    assign CC_WRPORT_ARBITER_Selection_Out  = sel_q;
    assign CC_WRPORT_ARBITER_Data_Out       = data_q;
    assign CC_WRPORT_ARBITER_WriteValid_Out = wv_q;
    assign CC_WRPORT_ARBITER_Error_Out      = err_q;

endmodule

// File: tb/tb_cc_wrport_arbiter.sv
// Directed bench for cc_wrport_arbiter; expectations follow CC_WRPORT_ARBITER_RR_EN when defined.
module tb_cc_wrport_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [17:0] addr;
    logic [95:0] data;
    logic [2:0]  grant;
    logic [5:0]  sel;
    logic [31:0] dout;
    logic        wv;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;

    cc_wrport_arbiter dut (
        .CC_WRPORT_ARBITER_CLOCK_50      (clk),
        .CC_WRPORT_ARBITER_RESET_InLow   (rst_n),
        .CC_WRPORT_ARBITER_Req_In        (req),
        .CC_WRPORT_ARBITER_Addr_In       (addr),
        .CC_WRPORT_ARBITER_Data_In       (data),
        .CC_WRPORT_ARBITER_Grant_Out     (grant),
        .CC_WRPORT_ARBITER_Selection_Out (sel),
        .CC_WRPORT_ARBITER_Data_Out      (dout),
        .CC_WRPORT_ARBITER_WriteValid_Out(wv),
        .CC_WRPORT_ARBITER_Error_Out     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] g, input logic [5:0] s,
                           input logic [31:0] d, input logic v, input logic e);
        chk({tag, ".grant"}, 64'(grant), 64'(g));
        chk({tag, ".sel"},   64'(sel),   64'(s));
        chk({tag, ".data"},  64'(dout),  64'(d));
        chk({tag, ".wv"},    64'(wv),    64'(v));
        chk({tag, ".err"},   64'(err),   64'(e));
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 3'b001;
        addr  = {6'd0, 6'd0, 6'd5};
        data  = {32'h0, 32'h0, 32'hDEADBEEF};
        #1;
        chk_all("reset", 3'b000, 6'd0, 32'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;

        // First grant after reset release, then idle once the request drops
        tick();
        chk_all("first", 3'b001, 6'd5, 32'hDEADBEEF, 1'b1, 1'b0);
        req = 3'b000;
        tick();
        chk_all("idle", 3'b000, 6'd0, 32'h0, 1'b0, 1'b0);

        // Fresh reset so the pointer restarts at the last requester
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        req  = 3'b111;
        addr = {6'd3, 6'd2, 6'd1};
        data = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
        tick();
        chk("arb1.grant", 64'(grant), 64'(3'b001));
        chk("arb1.sel",   64'(sel),   64'(6'd1));
        chk("arb1.data",  64'(dout),  64'(32'hAAAA0001));
        tick();
        chk("arb2.grant", 64'(grant), 64'(3'b010));
        chk("arb2.sel",   64'(sel),   64'(6'd2));
        chk("arb2.data",  64'(dout),  64'(32'hBBBB0002));
        tick();
`ifdef CC_WRPORT_ARBITER_RR_EN
        chk("arb3.grant", 64'(grant), 64'(3'b100));
        chk("arb3.sel",   64'(sel),   64'(6'd3));
        tick();
        chk("arb4.grant", 64'(grant), 64'(3'b001));
        chk("arb4.sel",   64'(sel),   64'(6'd1));
`else
        chk("arb3.grant", 64'(grant), 64'(3'b001));
        chk("arb3.sel",   64'(sel),   64'(6'd1));
        tick();
        chk("arb4.grant", 64'(grant), 64'(3'b010));
        chk("arb4.sel",   64'(sel),   64'(6'd2));
`endif
        req = 3'b000;
        tick();
        chk_all("idle2", 3'b000, 6'd0, 32'h0, 1'b0, 1'b0);

        // Address 0: consumed with no write and no error
        req  = 3'b010;
        addr = {6'd3, 6'd0, 6'd1};
        tick();
        chk_all("addr0", 3'b010, 6'd0, 32'hBBBB0002, 1'b0, 1'b0);
        req = 3'b000;
        tick();

        // Out-of-range address 38 sets the sticky error
        req  = 3'b100;
        addr = {6'd38, 6'd0, 6'd1};
        tick();
        chk_all("oor38", 3'b100, 6'd0, 32'hCCCC0003, 1'b0, 1'b1);
        req = 3'b000;
        tick();
        chk_all("sticky", 3'b000, 6'd0, 32'h0, 1'b0, 1'b1);

        // Address 63, then a valid write while the error stays set
        req  = 3'b100;
        addr = {6'd63, 6'd0, 6'd7};
        tick();
        chk_all("oor63", 3'b100, 6'd0, 32'hCCCC0003, 1'b0, 1'b1);
        req  = 3'b001;
        data = {32'hCCCC0003, 32'hBBBB0002, 32'h12345678};
        tick();
        chk_all("valid_err", 3'b001, 6'd7, 32'h12345678, 1'b1, 1'b1);

        // Reset mid grant cycle clears everything without a clock edge
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 3'b000, 6'd0, 32'h0, 1'b0, 1'b0);
        req  = 3'b110;
        addr = {6'd9, 6'd4, 6'd7};
        #1;
        rst_n = 1'b1;
        tick();
        chk_all("post_rst", 3'b010, 6'd4, 32'hBBBB0002, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
